// File: rtl/pcm_to_pdm_tx.sv
// rtl/pcm_to_pdm_tx.sv - PCM to PDM transmitter: first-order error-feedback modulator with PDM clock generator
// Optional LFSR dither on the accumulator update is enabled by defining PDM_TX_DITHER_EN.
module pcm_to_pdm_tx #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int PDM_CLK_FREQ = 1_800_000,
    parameter int DATA_WIDTH   = 16,
    parameter int OVERSAMPLE   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] pcm_data,
    input  logic                  pcm_valid,
    output logic                  pcm_ready,
    output logic                  PDM_CLK,
    output logic                  PDM_DATA,
    output logic                  underrun
);

    localparam int HP_RAW = CLK_FREQ / (2 * PDM_CLK_FREQ);
    localparam int HP     = (HP_RAW < 1) ? 1 : HP_RAW;
    localparam int DIV_W  = (HP > 1) ? $clog2(HP) : 1;
    localparam int CNT_W  = $clog2(OVERSAMPLE);
    localparam int ACC_W  = DATA_WIDTH + 2;
    localparam int SUM_W  = DATA_WIDTH + 4;

    localparam logic [SUM_W-1:0] ONE_S   = {{(SUM_W-1){1'b0}}, 1'b1};
    localparam logic [SUM_W-1:0] FS_S    = {{(SUM_W-DATA_WIDTH){1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [SUM_W-1:0] NEG_FS  = ~FS_S + ONE_S;
    localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HP - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state;
    logic [DIV_W-1:0]        div;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    first_fall;
    logic [DATA_WIDTH-1:0]   buf_data;
    logic                    buf_full;
    logic [DATA_WIDTH-1:0]   cur_sample;
    logic [ACC_W-1:0]        acc;

    logic                    half_tick;
    logic                    fall_tick;
    logic                    reload;
    logic                    hs;
    logic                    buf_full_nx;
    logic [SUM_W-1:0]        dith_term;
    logic [SUM_W-1:0]        sum;
    logic [ACC_W-1:0]        acc_next;

    assign half_tick   = (state == RUN) && (div == DIV_LAST);
    assign fall_tick   = half_tick && PDM_CLK;
    assign reload      = fall_tick && ((bit_cnt == CNT_LAST) || first_fall);
    assign hs          = pcm_valid && pcm_ready;
    // A reload empties the buffer; a handshake in the same cycle refills it.
    assign buf_full_nx = (buf_full && !reload) || hs;

`ifdef PDM_TX_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else if (fall_tick) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign dith_term = lfsr[0] ? ONE_S : {SUM_W{1'b1}};
`else
    assign dith_term = {SUM_W{1'b0}};
`endif

    always_comb begin
        sum = {{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc}
            + {{(SUM_W-DATA_WIDTH){cur_sample[DATA_WIDTH-1]}}, cur_sample}
            + (PDM_DATA ? NEG_FS : FS_S)
            + dith_term;
        if ($signed(sum) > $signed(ACC_MAX)) begin
            acc_next = ACC_MAX[ACC_W-1:0];
        end else if ($signed(sum) < $signed(ACC_MIN)) begin
            acc_next = ACC_MIN[ACC_W-1:0];
        end else begin
            acc_next = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            div        <= '0;
            bit_cnt    <= '0;
            first_fall <= 1'b0;
            buf_data   <= '0;
            buf_full   <= 1'b0;
            cur_sample <= '0;
            acc        <= '0;
            pcm_ready  <= 1'b0;
            PDM_CLK    <= 1'b0;
            PDM_DATA   <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            underrun  <= 1'b0;
            buf_full  <= buf_full_nx;
            pcm_ready <= !buf_full_nx;
            if (hs) begin
                buf_data <= pcm_data;
            end

            unique case (state)
                IDLE: begin
                    div      <= '0;
                    bit_cnt  <= '0;
                    acc      <= '0;
                    PDM_CLK  <= 1'b0;
                    PDM_DATA <= 1'b0;
                    if (enable) begin
                        state      <= RUN;
                        first_fall <= 1'b1;
                    end
                end
                RUN: begin
                    if (half_tick) begin
                        div     <= '0;
                        PDM_CLK <= !PDM_CLK;
                    end else begin
                        div <= div + 1'b1;
                    end

                    if (fall_tick) begin
                        first_fall <= 1'b0;
                        bit_cnt    <= (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;
                        acc        <= acc_next;
                        PDM_DATA   <= !acc_next[ACC_W-1];
                        if (reload) begin
                            if (buf_full) begin
                                cur_sample <= buf_data;
                            end else begin
                                cur_sample <= '0;
                                underrun   <= 1'b1;
                            end
                        end
                        // Leaving RUN only here means the current PDM period always completes.
                        if (!enable) begin
                            state    <= IDLE;
                            bit_cnt  <= '0;
                            acc      <= '0;
                            PDM_DATA <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
